// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, threshold flags, synchronous flush and sticky error flags.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned FWFT     = FIFO_STD,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    err_clr,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    fifo_full,
    output logic                    almost_full,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    output logic                    fifo_empty,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned     ADDR_W  = clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    logic             r_overflow;
    logic             r_underflow;

    logic [ADDR_W:0]  w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic [WIDTH-1:0] w_head;

    // Pointer difference wraps naturally through the extra MSB.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == DEPTH_C);
    assign w_empty = (w_count == '0);

    assign w_wr_acc  = wr_en & ~w_full  & ~flush;
    assign w_rd_acc  = rd_en & ~w_empty & ~flush;
    assign w_ovf_evt = wr_en &  w_full  & ~flush;
    assign w_udf_evt = rd_en &  w_empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_evt | (r_overflow  & ~err_clr);
            r_underflow <= w_udf_evt | (r_underflow & ~err_clr);
        end
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_head)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign rd_data  = w_empty ? '0 : w_head;
            assign rd_valid = ~w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_rd_data;
            logic             r_rd_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= w_head;
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign count        = w_count;
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign almost_full  = (w_count >= AF_C);
    assign almost_empty = (w_count <= AE_C);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: instance 0 in standard mode, instance 1 in
// FWFT mode, both checked every cycle against a queue-level model.
module tb_sync_fifo;

    localparam int unsigned D = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wr_en = '0, rd_en = '0, flush = '0, err_clr = '0;
    logic [15:0] wr_data [2] = '{16'h0, 16'h0};

    logic [1:0]  fifo_full, almost_full, rd_valid, fifo_empty, almost_empty;
    logic [1:0]  overflow, underflow;
    logic [15:0] rd_data [2];
    logic [5:0]  count [2];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Model state: occupancy as a plain integer over a circular buffer.
    logic [15:0] mbuf [2][D];
    int unsigned mhead [2] = '{0, 0};
    int unsigned mcnt  [2] = '{0, 0};
    logic [15:0] mrd   [2] = '{16'h0, 16'h0};
    bit          mvalid[2] = '{0, 0};
    bit          movf  [2] = '{0, 0};
    bit          mudf  [2] = '{0, 0};
    bit          m_full, m_empty;

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(16), .DEPTH(32), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .flush(flush[0]), .err_clr(err_clr[0]),
        .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .fifo_full(fifo_full[0]), .almost_full(almost_full[0]),
        .rd_en(rd_en[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .fifo_empty(fifo_empty[0]), .almost_empty(almost_empty[0]),
        .count(count[0]), .overflow(overflow[0]), .underflow(underflow[0])
    );

    sync_fifo #(.WIDTH(16), .DEPTH(32), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush[1]), .err_clr(err_clr[1]),
        .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .fifo_full(fifo_full[1]), .almost_full(almost_full[1]),
        .rd_en(rd_en[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .fifo_empty(fifo_empty[1]), .almost_empty(almost_empty[1]),
        .count(count[1]), .overflow(overflow[1]), .underflow(underflow[1])
    );

    task automatic chk(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mcnt[k] = 0; mhead[k] = 0; mrd[k] = '0;
                mvalid[k] = 0; movf[k] = 0; mudf[k] = 0;
            end else begin
                m_full  = (mcnt[k] == D);
                m_empty = (mcnt[k] == 0);
                movf[k] = (movf[k] && !err_clr[k]) || (!flush[k] && wr_en[k] && m_full);
                mudf[k] = (mudf[k] && !err_clr[k]) || (!flush[k] && rd_en[k] && m_empty);
                if (flush[k]) begin
                    mcnt[k] = 0; mhead[k] = 0; mvalid[k] = 0;
                end else begin
                    if (rd_en[k] && !m_empty) begin
                        mrd[k]    = mbuf[k][mhead[k]];
                        mhead[k]  = (mhead[k] + 1) % D;
                        mcnt[k]   = mcnt[k] - 1;
                        mvalid[k] = 1;
                    end else begin
                        mvalid[k] = 0;
                    end
                    if (wr_en[k] && !m_full) begin
                        mbuf[k][(mhead[k] + mcnt[k]) % D] = wr_data[k];
                        mcnt[k] = mcnt[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < 2; k++) begin
                logic [15:0] exp_data;
                bit          exp_valid;
                if (k == 1) begin
                    exp_data  = (mcnt[k] == 0) ? 16'h0 : mbuf[k][mhead[k]];
                    exp_valid = (mcnt[k] != 0);
                end else begin
                    exp_data  = mrd[k];
                    exp_valid = mvalid[k];
                end
                chk("count",        k, 32'(count[k]),        mcnt[k]);
                chk("fifo_full",    k, 32'(fifo_full[k]),    32'(mcnt[k] == D));
                chk("fifo_empty",   k, 32'(fifo_empty[k]),   32'(mcnt[k] == 0));
                chk("almost_full",  k, 32'(almost_full[k]),  32'(mcnt[k] >= 28));
                chk("almost_empty", k, 32'(almost_empty[k]), 32'(mcnt[k] <= 4));
                chk("rd_data",      k, 32'(rd_data[k]),      32'(exp_data));
                chk("rd_valid",     k, 32'(rd_valid[k]),     32'(exp_valid));
                chk("overflow",     k, 32'(overflow[k]),     32'(movf[k]));
                chk("underflow",    k, 32'(underflow[k]),    32'(mudf[k]));
            end
        end
    end

    task automatic drive(input int k, input bit we, input logic [15:0] wd,
                         input bit re, input bit fl = 0, input bit ec = 0);
        wr_en[k] = we; wr_data[k] = wd; rd_en[k] = re;
        flush[k] = fl; err_clr[k] = ec;
        @(negedge clk);
        wr_en[k] = 0; rd_en[k] = 0; flush[k] = 0; err_clr[k] = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", 0, 32'(count[0]), 0);
        chk("rst_empty", 0, 32'(fifo_empty[0]), 1);
        chk("rst_ae",    0, 32'(almost_empty[0]), 1);
        chk("rst_full",  0, 32'(fifo_full[0]), 0);
        chk("rst_rdata", 0, 32'(rd_data[0]), 0);
        chk("rst_valid", 0, 32'(rd_valid[0]), 0);

        for (int i = 1; i <= 7; i++) drive(0, 1, 16'(i), 0);
        chk("fill7_count", 0, 32'(count[0]), 7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 0, 32'(count[0]), 0);
        chk("async_rst_empty", 0, 32'(fifo_empty[0]), 1);
        @(negedge clk);
        rst = 1'b0;

        drive(0, 1, 16'd3, 0);
        drive(0, 1, 16'd9, 0);
        drive(0, 1, 16'd12, 0);
        drive(0, 0, 16'd0, 1);
        chk("rd1_data",  0, 32'(rd_data[0]), 3);
        chk("rd1_valid", 0, 32'(rd_valid[0]), 1);
        drive(0, 0, 16'd0, 1);
        chk("rd2_data",  0, 32'(rd_data[0]), 9);
        chk("rd2_count", 0, 32'(count[0]), 1);
        drive(0, 0, 16'd0, 0);
        chk("hold_data",  0, 32'(rd_data[0]), 9);
        chk("hold_valid", 0, 32'(rd_valid[0]), 0);
        drive(0, 0, 16'd0, 1);

        drive(0, 1, 16'h55, 1);
        chk("wr_rd_empty_count", 0, 32'(count[0]), 1);
        chk("wr_rd_empty_udf",   0, 32'(underflow[0]), 1);
        drive(0, 0, 16'd0, 1, 0, 1);
        chk("errclr_udf", 0, 32'(underflow[0]), 0);
        drive(0, 0, 16'd0, 1, 0, 1);
        chk("errclr_vs_event_udf", 0, 32'(underflow[0]), 1);
        drive(0, 0, 16'd0, 0, 0, 1);

        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 16'(100 + i), 0);
            if (i == 26) chk("af_at27", 0, 32'(almost_full[0]), 0);
            if (i == 27) chk("af_at28", 0, 32'(almost_full[0]), 1);
            if (i == 30) chk("full_at31", 0, 32'(fifo_full[0]), 0);
        end
        chk("full_at32", 0, 32'(fifo_full[0]), 1);
        drive(0, 1, 16'hDEAD, 0);
        chk("ovf_count", 0, 32'(count[0]), 32);
        chk("ovf_flag",  0, 32'(overflow[0]), 1);
        drive(0, 0, 16'd0, 0, 0, 1);
        chk("ovf_clr", 0, 32'(overflow[0]), 0);

        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 16'(200 + i), 1);
            if (i == 0) begin
                chk("full_wr_rd_count", 0, 32'(count[0]), 31);
                chk("full_wr_rd_ovf",   0, 32'(overflow[0]), 1);
                chk("full_wr_rd_data",  0, 32'(rd_data[0]), 100);
            end
        end
        chk("steady31_count", 0, 32'(count[0]), 31);
        chk("steady31_data",  0, 32'(rd_data[0]), 109);
        drive(0, 1, 16'd7, 1, 1, 1);
        chk("flush_count", 0, 32'(count[0]), 0);
        chk("flush_valid", 0, 32'(rd_valid[0]), 0);
        chk("flush_ovf",   0, 32'(overflow[0]), 0);

        for (int i = 0; i < 5; i++) drive(0, 1, 16'(i + 1), 0);
        for (int i = 0; i < 100; i++) drive(0, 1, 16'($urandom), 1);
        chk("stream_count", 0, 32'(count[0]), 5);
        drive(0, 1, 16'h1234, 1, 1, 0);
        chk("flush2_count", 0, 32'(count[0]), 0);
        chk("flush2_empty", 0, 32'(fifo_empty[0]), 1);
        chk("flush2_udf",   0, 32'(underflow[0]), 0);
        chk("flush2_ovf",   0, 32'(overflow[0]), 0);

        drive(1, 1, 16'hA5A5, 0);
        chk("fwft_data",  1, 32'(rd_data[1]), 32'hA5A5);
        chk("fwft_empty", 1, 32'(fifo_empty[1]), 0);
        chk("fwft_valid", 1, 32'(rd_valid[1]), 1);
        drive(1, 0, 16'd0, 1);
        chk("fwft_pop_empty", 1, 32'(fifo_empty[1]), 1);
        chk("fwft_pop_data",  1, 32'(rd_data[1]), 0);
        drive(1, 0, 16'd0, 1);
        chk("fwft_udf", 1, 32'(underflow[1]), 1);
        drive(1, 0, 16'd0, 0, 0, 1);
        chk("fwft_udf_clr", 1, 32'(underflow[1]), 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
